alu_exec_unit: RTL and testbench

Execute-stage ALU that consumes the 3-bit `ALUControl` code produced by the ALU decoder and performs the selected operation on two operands. Add, subtract and set-less-than complete in one registered cycle. Multiply (`ALUControl` = 101) runs on an iterative shift-add datapath over `WIDTH` cycles. A start/busy/done handshake lets the control path stall the pipeline while a multiply is in flight.

---
 rtl/alu_exec_unit_if.sv | 37 +++
 rtl/alu_exec_unit.sv | 119 +++++++++++
 tb/tb_alu_exec_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Operand/result bus of the execute-stage ALU.
// The control path drives the request side through the master modport;
// the ALU drives the result/handshake side through the slave modport.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output ALUControl,
        output SrcA,
        output SrcB,
        input  ALUResult,
        input  Zero,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  ALUControl,
        input  SrcA,
        input  SrcB,
        output ALUResult,
        output Zero,
        output busy,
        output done
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: add/sub/slt finish in one registered cycle, multiply
// runs WIDTH iterations on a shift-add datapath. busy/done let the control
// path stall the pipeline while a multiply is in flight.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_exec_unit_if.slave        bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;

    logic             w_canAccept;
    logic             w_accept;
    logic             w_isMul;
    logic             w_lastIter;
    logic             w_lt;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w_accSum;

    // A new request is taken only when no multiply is iterating.
    assign w_canAccept = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept    = w_canAccept && bus.start;
    assign w_isMul     = (bus.ALUControl == 3'b101);
    assign w_lastIter  = (r_count == CW'(WIDTH - 1));
    assign w_lt        = ($signed(bus.SrcA) < $signed(bus.SrcB));
    assign w_accSum    = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Single-cycle result straight from the live operands; unknown codes add.
    always_comb begin
        w_single = bus.SrcA + bus.SrcB;
        case (bus.ALUControl)
            3'b100:  w_single = bus.SrcA - bus.SrcB;
            3'b110:  w_single = {{(WIDTH-1){1'b0}}, w_lt};
            default: w_single = bus.SrcA + bus.SrcB;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: DONE behaves like IDLE for back-to-back requests.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_nextState = w_isMul ? S_MUL : S_DONE;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            S_MUL: begin
                if (w_lastIter) begin
                    w_nextState = S_DONE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath: latch multiply operands, iterate shift-add, publish results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            if (w_isMul) begin
                r_mcand  <= bus.SrcA;
                r_mplier <= bus.SrcB;
                r_acc    <= '0;
                r_count  <= '0;
            end else begin
                r_result <= w_single;
                r_zero   <= (w_single == '0);
            end
        end else if (r_state == S_MUL) begin
            r_acc    <= w_accSum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
            if (w_lastIter) begin
                r_result <= w_accSum;
                r_zero   <= (w_accSum == '0);
            end
        end
    end

    assign bus.ALUResult = r_result;
    assign bus.Zero      = r_zero;
    assign bus.busy      = (r_state == S_MUL);
    assign bus.done      = (r_state == S_DONE);
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases with literal
// expectations plus randomized traffic against a latency-based model.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic clk;
    logic rst;
    logic checkEn;
    int   checksTotal;
    int   checksPassed;

    alu_exec_unit_if #(.WIDTH(W)) bus();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: remaining multiply cycles and the values the outputs must show.
    int         mWait;
    logic [W-1:0] mPending;
    logic [W-1:0] mResult;
    logic       mZero;
    logic       mDone;

    function automatic logic [W-1:0] refOp(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            3'b100:  return a - b;
            3'b110:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: return a + b;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a request taken while idle either completes next cycle
    // or, for multiply, after W busy cycles with the low W bits of a*b.
    always @(posedge clk) begin
        if (rst) begin
            mWait   <= 0;
            mResult <= '0;
            mZero   <= 1'b1;
            mDone   <= 1'b0;
        end else if (mWait > 0) begin
            if (mWait == 1) begin
                mResult <= mPending;
                mZero   <= (mPending == '0);
                mDone   <= 1'b1;
            end else begin
                mDone <= 1'b0;
            end
            mWait <= mWait - 1;
        end else if (bus.start) begin
            if (bus.ALUControl == 3'b101) begin
                mPending <= bus.SrcA * bus.SrcB;
                mWait    <= W;
                mDone    <= 1'b0;
            end else begin
                mResult <= refOp(bus.ALUControl, bus.SrcA, bus.SrcB);
                mZero   <= (refOp(bus.ALUControl, bus.SrcA, bus.SrcB) == '0);
                mDone   <= 1'b1;
            end
        end else begin
            mDone <= 1'b0;
        end
    end

    // Every cycle, once reset has been applied, compare DUT outputs with the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("modelALUResult", 64'(bus.ALUResult), 64'(mResult));
            checkOutput("modelZero", 64'(bus.Zero), 64'(mZero));
            checkOutput("modelBusy", 64'(bus.busy), 64'(mWait > 0));
            checkOutput("modelDone", 64'(bus.done), 64'(mDone));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle, then scramble the operands.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
        bus.start      = 1'b1;
        bus.ALUControl = op;
        bus.SrcA       = a;
        bus.SrcB       = b;
        step();
        bus.start      = 1'b0;
        bus.ALUControl = 3'($urandom_range(0, 7));
        bus.SrcA       = W'($urandom);
        bus.SrcB       = W'($urandom);
    endtask

    // Count busy cycles until done, optionally pulsing an add request at iteration pokeAt.
    task automatic waitDone(input int pokeAt, output int busyCycles, output int doneCycle);
        busyCycles = 0;
        doneCycle  = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == pokeAt) begin
                bus.start      = 1'b1;
                bus.ALUControl = 3'b010;
                bus.SrcA       = W'(1);
                bus.SrcB       = W'(1);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (bus.busy) busyCycles++;
            if (bus.done) begin
                doneCycle = k;
                break;
            end
            step();
        end
        bus.start = 1'b0;
        step();
    endtask

    // Directed cases first, then randomized traffic, then the summary.
    initial begin
        int busyCycles;
        int doneCycle;
        checkEn        = 1'b0;
        checksTotal    = 0;
        checksPassed   = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.ALUControl = 3'b010;
        bus.SrcA       = '0;
        bus.SrcB       = '0;
        repeat (3) step();
        checkEn = 1'b1;
        rst     = 1'b0;

        @(negedge clk);
        checkOutput("resetResult", 64'(bus.ALUResult), 64'h0);
        checkOutput("resetZero", 64'(bus.Zero), 64'h1);
        checkOutput("resetBusy", 64'(bus.busy), 64'h0);
        checkOutput("resetDone", 64'(bus.done), 64'h0);
        step();

        applyStimulus(3'b010, W'(5), W'(7));
        @(negedge clk);
        checkOutput("add5p7", 64'(bus.ALUResult), 64'd12);
        checkOutput("add5p7Zero", 64'(bus.Zero), 64'h0);
        checkOutput("add5p7Done", 64'(bus.done), 64'h1);
        step();

        applyStimulus(3'b100, W'(5), W'(5));
        @(negedge clk);
        checkOutput("sub5m5", 64'(bus.ALUResult), 64'h0);
        checkOutput("sub5m5Zero", 64'(bus.Zero), 64'h1);
        step();

        applyStimulus(3'b110, 32'hFFFF_FFFF, W'(1));
        @(negedge clk);
        checkOutput("sltNeg1Lt1", 64'(bus.ALUResult), 64'h1);
        step();
        applyStimulus(3'b110, W'(1), 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("slt1LtNeg1", 64'(bus.ALUResult), 64'h0);
        step();
        applyStimulus(3'b111, W'(3), W'(4));
        @(negedge clk);
        checkOutput("code111Add", 64'(bus.ALUResult), 64'd7);
        step();

        applyStimulus(3'b101, 32'h0000_FFFF, 32'h0001_0001);
        waitDone(0, busyCycles, doneCycle);
        checkOutput("mulBusyCycles", 64'(busyCycles), 64'd32);
        checkOutput("mulDoneCycle", 64'(doneCycle), 64'd33);
        checkOutput("mulResult", 64'(bus.ALUResult), 64'hFFFF_FFFF);

        applyStimulus(3'b101, 32'h0, 32'h1234_5678);
        waitDone(0, busyCycles, doneCycle);
        checkOutput("mulZeroBusy", 64'(busyCycles), 64'd32);
        checkOutput("mulZeroDoneCycle", 64'(doneCycle), 64'd33);
        checkOutput("mulZeroResult", 64'(bus.ALUResult), 64'h0);
        checkOutput("mulZeroZero", 64'(bus.Zero), 64'h1);

        applyStimulus(3'b101, 32'h0000_1234, 32'h0000_5678);
        waitDone(10, busyCycles, doneCycle);
        checkOutput("pokeBusyCycles", 64'(busyCycles), 64'd32);
        checkOutput("pokeDoneCycle", 64'(doneCycle), 64'd33);
        checkOutput("pokeResult", 64'(bus.ALUResult), 64'h0626_0060);

        applyStimulus(3'b101, 32'h0000_00FF, 32'h0000_0101);
        repeat (14) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abortResult", 64'(bus.ALUResult), 64'h0);
        checkOutput("abortZero", 64'(bus.Zero), 64'h1);
        checkOutput("abortBusy", 64'(bus.busy), 64'h0);
        checkOutput("abortDone", 64'(bus.done), 64'h0);
        step();
        applyStimulus(3'b010, W'(2), W'(3));
        @(negedge clk);
        checkOutput("addAfterAbort", 64'(bus.ALUResult), 64'd5);
        step();

        applyStimulus(3'b101, W'(3), W'(4));
        for (int k = 0; k < 60 && !bus.done; k++) step();
        checkOutput("b2bMulDone", 64'(bus.done), 64'h1);
        checkOutput("b2bMulResult", 64'(bus.ALUResult), 64'd12);
        applyStimulus(3'b100, W'(10), W'(4));
        @(negedge clk);
        checkOutput("b2bSubDone", 64'(bus.done), 64'h1);
        checkOutput("b2bSubResult", 64'(bus.ALUResult), 64'd6);
        step();

        for (int n = 0; n < 1500; n++) begin
            int sel;
            sel            = int'($urandom_range(0, 5));
            rst            = ($urandom_range(0, 299) == 0);
            bus.start      = ($urandom_range(0, 1) == 1);
            bus.ALUControl = (sel == 0) ? 3'b010 : (sel == 1) ? 3'b100 :
                             (sel == 2) ? 3'b110 : (sel == 3) ? 3'b101 :
                             3'($urandom_range(0, 7));
            bus.SrcA       = ($urandom_range(0, 7) == 0) ? bus.SrcB : W'($urandom);
            bus.SrcB       = W'($urandom);
            step();
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (40) step();

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule
